// File: rtl/cr16_ctrl_pkg.sv
// Shared encodings for the CR16-subset control unit:
// states, opcodes, condition codes, PSR bits, mux selects.
package cr16_ctrl_pkg;

   localparam int WIDTH     = 16;
   localparam int PSRL      = 5;
   localparam int STATEBITS = 4;

   typedef enum logic [STATEBITS-1:0] {
      S_FETCH   = 4'd0,
      S_FLATCH  = 4'd1,
      S_DECODE  = 4'd2,
      S_EX_R    = 4'd3,
      S_EX_I    = 4'd4,
      S_ALU_WB  = 4'd5,
      S_MOV_WB  = 4'd6,
      S_LD_ADDR = 4'd7,
      S_LD_WAIT = 4'd8,
      S_LD_WB   = 4'd9,
      S_ST      = 4'd10,
      S_BR_EX   = 4'd11,
      S_BR_TAKE = 4'd12,
      S_JMP     = 4'd13,
      S_PC_INC  = 4'd14,
      S_PC_WR   = 4'd15
   } state_e;

   // ALU codes appear both as R-type ext and as immediate-form op
   localparam logic [3:0] OP_RTYPE = 4'b0000;
   localparam logic [3:0] ALU_ADD  = 4'b0101;
   localparam logic [3:0] ALU_SUB  = 4'b1001;
   localparam logic [3:0] ALU_CMP  = 4'b1011;
   localparam logic [3:0] ALU_AND  = 4'b0001;
   localparam logic [3:0] ALU_OR   = 4'b0010;
   localparam logic [3:0] ALU_XOR  = 4'b0011;
   localparam logic [3:0] OP_MOV   = 4'b1101;
   localparam logic [3:0] OP_LDST  = 4'b0100;
   localparam logic [3:0] OP_BCOND = 4'b1100;

   localparam logic [3:0] EXT_MOV   = 4'b1101;
   localparam logic [3:0] EXT_LOAD  = 4'b0000;
   localparam logic [3:0] EXT_STOR  = 4'b0100;
   localparam logic [3:0] EXT_JCOND = 4'b1100;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_HI = 4'b0100;
   localparam logic [3:0] COND_LS = 4'b0101;
   localparam logic [3:0] COND_GT = 4'b0110;
   localparam logic [3:0] COND_LE = 4'b0111;
   localparam logic [3:0] COND_FS = 4'b1000;
   localparam logic [3:0] COND_FC = 4'b1001;
   localparam logic [3:0] COND_LO = 4'b1010;
   localparam logic [3:0] COND_HS = 4'b1011;
   localparam logic [3:0] COND_LT = 4'b1100;
   localparam logic [3:0] COND_GE = 4'b1101;
   localparam logic [3:0] COND_UC = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

   localparam int PSR_N = 4;
   localparam int PSR_Z = 3;
   localparam int PSR_F = 2;
   localparam int PSR_L = 1;
   localparam int PSR_C = 0;

   localparam logic       PC_RSRC    = 1'b0;
   localparam logic       PC_ALU     = 1'b1;
   localparam logic       MEM_RDEST  = 1'b0;
   localparam logic       MEM_PC     = 1'b1;
   localparam logic [1:0] WD_IMM     = 2'b00;
   localparam logic [1:0] WD_RSRC    = 2'b01;
   localparam logic [1:0] WD_MEM     = 2'b10;
   localparam logic [1:0] WD_ALU     = 2'b11;
   localparam logic [1:0] ALUA_RSRC  = 2'b00;
   localparam logic [1:0] ALUA_PC    = 2'b01;
   localparam logic [1:0] ALUA_IMM   = 2'b10;
   localparam logic [1:0] ALUB_RDEST = 2'b00;
   localparam logic [1:0] ALUB_IMM   = 2'b01;
   localparam logic [1:0] ALUB_ONE   = 2'b10;

   typedef struct packed {
      logic       pc_s;
      logic       mem_s;
      logic [1:0] wd_s;
      logic [1:0] alua_s;
      logic [1:0] alub_s;
      logic       inst_en;
      logic       alu_out_en;
      logic       mem_reg_en;
      logic       pc_en;
      logic       psr_en;
      logic       se_sign;
      logic       reg_wr;
      logic       mem_we;
      logic       force_add;
      logic       illegal;
   } ctrl_t;

   function automatic logic is_alu(input logic [3:0] c);
      return c inside {ALU_ADD, ALU_SUB, ALU_CMP,
                       ALU_AND, ALU_OR, ALU_XOR};
   endfunction

   // Arithmetic ops update flags and take signed immediates
   function automatic logic is_arith(input logic [3:0] c);
      return c inside {ALU_ADD, ALU_SUB, ALU_CMP};
   endfunction

endpackage

// File: rtl/cr16_controller_if.sv
// Controller <-> datapath bundle: instruction/PSR in,
// selects, enables and strobes out.
interface cr16_controller_if;
   import cr16_ctrl_pkg::*;

   logic [WIDTH-1:0]     instr;
   logic [PSRL-1:0]      psr;
   logic                 pc_s;
   logic                 mem_s;
   logic [1:0]           wd_s;
   logic [1:0]           alua_s;
   logic [1:0]           alub_s;
   logic                 inst_en;
   logic                 alu_out_en;
   logic                 mem_reg_en;
   logic                 pc_en;
   logic                 psr_en;
   logic                 se_sign;
   logic                 reg_wr;
   logic                 mem_we;
   logic                 force_add;
   logic                 illegal;
   logic [STATEBITS-1:0] state;

   modport master (
      input  instr, psr,
      output pc_s, mem_s, wd_s, alua_s, alub_s,
      output inst_en, alu_out_en, mem_reg_en,
      output pc_en, psr_en, se_sign, reg_wr,
      output mem_we, force_add, illegal, state
   );

   modport slave (
      output instr, psr,
      input  pc_s, mem_s, wd_s, alua_s, alub_s,
      input  inst_en, alu_out_en, mem_reg_en,
      input  pc_en, psr_en, se_sign, reg_wr,
      input  mem_we, force_add, illegal, state
   );

endinterface

// File: rtl/cr16_controller_cond_eval.sv
// Branch/jump condition evaluator: cond code + PSR -> taken.
module cr16_cond_eval
   import cr16_ctrl_pkg::*;
(
   input  logic [3:0]      cond_i,
   input  logic [PSRL-1:0] psr_i,
   output logic            taken_o
);

   logic n, z, f, l, c;

   assign n = psr_i[PSR_N];
   assign z = psr_i[PSR_Z];
   assign f = psr_i[PSR_F];
   assign l = psr_i[PSR_L];
   assign c = psr_i[PSR_C];

   always_comb begin
      taken_o = 1'b0;
      unique case (cond_i)
         COND_EQ: taken_o = z;
         COND_NE: taken_o = !z;
         COND_CS: taken_o = c;
         COND_CC: taken_o = !c;
         COND_HI: taken_o = l;
         COND_LS: taken_o = !l;
         COND_GT: taken_o = n;
         COND_LE: taken_o = !n;
         COND_FS: taken_o = f;
         COND_FC: taken_o = !f;
         COND_LO: taken_o = !l && !z;
         COND_HS: taken_o = l || z;
         COND_LT: taken_o = !n && !z;
         COND_GE: taken_o = n || z;
         COND_UC: taken_o = 1'b1;
         COND_NV: taken_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/cr16_controller.sv
// Multicycle Moore control FSM for the CR16-subset core;
// one instruction at a time, FETCH to FETCH.
module cr16_controller
   import cr16_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   cr16_controller_if.master bus
);

   state_e     state_q, state_d;
   ctrl_t      ctrl;
   logic [3:0] op, cond, ext;
   logic       taken;
   logic       is_r, is_mov, is_imm, is_movi;
   logic       is_ld, is_st, is_jc, is_bc;
   logic       unused_rsrc;

   assign op          = bus.instr[15:12];
   assign cond        = bus.instr[11:8];
   assign ext         = bus.instr[7:4];
   assign unused_rsrc = ^bus.instr[3:0];

   assign is_r    = (op == OP_RTYPE) && is_alu(ext);
   assign is_mov  = (op == OP_RTYPE) && (ext == EXT_MOV);
   assign is_imm  = is_alu(op);
   assign is_movi = (op == OP_MOV);
   assign is_ld   = (op == OP_LDST) && (ext == EXT_LOAD);
   assign is_st   = (op == OP_LDST) && (ext == EXT_STOR);
   assign is_jc   = (op == OP_LDST) && (ext == EXT_JCOND);
   assign is_bc   = (op == OP_BCOND);

   cr16_cond_eval u_cond (
      .cond_i  (cond),
      .psr_i   (bus.psr),
      .taken_o (taken)
   );

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      ctrl    = '0;
      unique case (state_q)
         S_FETCH: begin
            ctrl.mem_s = MEM_PC;
            state_d    = S_FLATCH;
         end
         S_FLATCH: begin
            ctrl.mem_s   = MEM_PC;
            ctrl.inst_en = 1'b1;
            state_d      = S_DECODE;
         end
         S_DECODE: begin
            unique case (1'b1)
               is_r:            state_d = S_EX_R;
               is_imm:          state_d = S_EX_I;
               is_mov, is_movi: state_d = S_MOV_WB;
               is_ld:           state_d = S_LD_ADDR;
               is_st:           state_d = S_ST;
               is_jc: state_d = taken ? S_JMP : S_PC_INC;
               is_bc: state_d = taken ? S_BR_EX : S_PC_INC;
               default: begin
                  ctrl.illegal = 1'b1;
                  state_d      = S_PC_INC;
               end
            endcase
         end
         S_EX_R: begin
            ctrl.alua_s     = ALUA_RSRC;
            ctrl.alub_s     = ALUB_RDEST;
            ctrl.alu_out_en = 1'b1;
            ctrl.psr_en     = is_arith(ext);
            state_d = (ext == ALU_CMP) ? S_PC_INC : S_ALU_WB;
         end
         S_EX_I: begin
            ctrl.alua_s     = ALUA_RSRC;
            ctrl.alub_s     = ALUB_IMM;
            ctrl.alu_out_en = 1'b1;
            ctrl.se_sign    = is_arith(op);
            ctrl.psr_en     = is_arith(op);
            state_d = (op == ALU_CMP) ? S_PC_INC : S_ALU_WB;
         end
         S_ALU_WB: begin
            ctrl.wd_s   = WD_ALU;
            ctrl.reg_wr = 1'b1;
            state_d     = S_PC_INC;
         end
         S_MOV_WB: begin
            ctrl.reg_wr  = 1'b1;
            ctrl.wd_s    = is_movi ? WD_IMM : WD_RSRC;
            ctrl.se_sign = is_movi;
            state_d      = S_PC_INC;
         end
         S_LD_ADDR: begin
            ctrl.mem_s = MEM_RDEST;
            state_d    = S_LD_WAIT;
         end
         S_LD_WAIT: begin
            ctrl.mem_s      = MEM_RDEST;
            ctrl.mem_reg_en = 1'b1;
            state_d         = S_LD_WB;
         end
         S_LD_WB: begin
            ctrl.wd_s   = WD_MEM;
            ctrl.reg_wr = 1'b1;
            state_d     = S_PC_INC;
         end
         S_ST: begin
            ctrl.mem_s  = MEM_RDEST;
            ctrl.mem_we = 1'b1;
            state_d     = S_PC_INC;
         end
         S_BR_EX: begin
            ctrl.alua_s     = ALUA_PC;
            ctrl.alub_s     = ALUB_IMM;
            ctrl.se_sign    = 1'b1;
            ctrl.force_add  = 1'b1;
            ctrl.alu_out_en = 1'b1;
            state_d         = S_BR_TAKE;
         end
         S_BR_TAKE: begin
            ctrl.pc_s  = PC_ALU;
            ctrl.pc_en = 1'b1;
            state_d    = S_FETCH;
         end
         S_JMP: begin
            ctrl.pc_s  = PC_RSRC;
            ctrl.pc_en = 1'b1;
            state_d    = S_FETCH;
         end
         S_PC_INC: begin
            ctrl.alua_s     = ALUA_PC;
            ctrl.alub_s     = ALUB_ONE;
            ctrl.force_add  = 1'b1;
            ctrl.alu_out_en = 1'b1;
            state_d         = S_PC_WR;
         end
         S_PC_WR: begin
            ctrl.pc_s  = PC_ALU;
            ctrl.pc_en = 1'b1;
            state_d    = S_FETCH;
         end
      endcase
      // Reset kills every strobe in the same cycle
      if (reset) ctrl = '0;
   end

   assign bus.pc_s       = ctrl.pc_s;
   assign bus.mem_s      = ctrl.mem_s;
   assign bus.wd_s       = ctrl.wd_s;
   assign bus.alua_s     = ctrl.alua_s;
   assign bus.alub_s     = ctrl.alub_s;
   assign bus.inst_en    = ctrl.inst_en;
   assign bus.alu_out_en = ctrl.alu_out_en;
   assign bus.mem_reg_en = ctrl.mem_reg_en;
   assign bus.pc_en      = ctrl.pc_en;
   assign bus.psr_en     = ctrl.psr_en;
   assign bus.se_sign    = ctrl.se_sign;
   assign bus.reg_wr     = ctrl.reg_wr;
   assign bus.mem_we     = ctrl.mem_we;
   assign bus.force_add  = ctrl.force_add;
   assign bus.illegal    = ctrl.illegal;
   assign bus.state      = reset ? S_FETCH : state_q;

endmodule

// File: doc/cr16_controller.md
Name: cr16_controller

Overview:
- Multicycle control FSM for the 16-bit CR16-subset core.
- Consumes the latched instruction word and the processor status register (PSR) from the datapath.
- Drives every mux select, register enable and write strobe the datapath needs, plus the memory write strobe.
- One instruction at a time, no overlap; sits beside the datapath inside the CPU top.

Parameters:
- WIDTH, 16, instruction width
- PSRL, 5, PSR width
- STATEBITS, 4, state register width (16 states)

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- instr  in  WIDTH  latched instruction register: op=[15:12], rdest/cond=[11:8], ext=[7:4], rsrc=[3:0]
- psr  in  PSRL  {N,Z,F,L,C} = psr[4:0]
- pc_s, mem_s  out  1  mux2 selects (pc_s: 0=Rsrc 1=alu_out; mem_s: 0=Rdest 1=pc)
- wd_s, alua_s, alub_s  out  2  mux4 selects (wd: 00 imm,01 Rsrc,10 mem_out,11 alu_out; alua: 00 Rsrc,01 pc,10 imm; alub: 00 Rdest,01 imm,10 one)
- inst_en, alu_out_en, mem_reg_en, pc_en, psr_en  out  1  register enables
- se_sign, reg_wr  out  1  sign-extend select, regfile write
- mem_we  out  1  data memory write strobe
- force_add  out  1  datapath ALU performs ADD regardless of decode
- illegal  out  1  one-cycle pulse on undecodable instruction
- state  out  STATEBITS  debug view of current state

Behaviour:
- Moore FSM. Outputs are a function of state and instr only. Every output defaults to 0 in every state unless listed below.
- Reset: state<=FETCH. During the reset cycle all outputs are forced to 0, state output reads FETCH. Reset in any state aborts the instruction with no write; FETCH starts the cycle after reset deasserts.
- FETCH: mem_s=1 -> FLATCH.
- FLATCH: mem_s=1, inst_en=1 -> DECODE. Memory read latency is 1 cycle.
- DECODE: no strobes. Transitions:
  - op 0000, ext in {0101 ADD, 1001 SUB, 1011 CMP, 0001 AND, 0010 OR, 0011 XOR} -> EX_R.
  - op 0000, ext 1101 MOV -> MOV_WB.
  - op in {0101, 1001, 1011, 0001, 0010, 0011} (immediate forms) -> EX_I.
  - op 1101 MOVI -> MOV_WB.
  - op 0100, ext 0000 LOAD -> LD_ADDR; ext 0100 STOR -> ST; ext 1100 Jcond -> JMP if cond true, else PC_INC.
  - op 1100 Bcond -> BR_EX if cond true, else PC_INC.
  - Anything else: illegal=1 -> PC_INC, executed as a NOP.
- Condition code = instr[11:8]:
  - EQ 0000 Z; NE 0001 !Z; CS 0010 C; CC 0011 !C; HI 0100 L; LS 0101 !L; GT 0110 N; LE 0111 !N.
  - FS 1000 F; FC 1001 !F; LO 1010 !L&!Z; HS 1011 L|Z; LT 1100 !N&!Z; GE 1101 N|Z; UC 1110 always; 1111 never.
- EX_R: alua_s=00, alub_s=00, alu_out_en=1. psr_en=1 for ADD/SUB/CMP. CMP -> PC_INC, else -> ALU_WB.
- EX_I: alua_s=00, alub_s=01, alu_out_en=1. se_sign=1 for ADDI/SUBI/CMPI, 0 for ANDI/ORI/XORI. psr_en as in EX_R. CMPI -> PC_INC, else -> ALU_WB.
- ALU_WB: wd_s=11, reg_wr=1 -> PC_INC.
- MOV_WB: reg_wr=1. wd_s=01 for MOV; wd_s=00 with se_sign=1 for MOVI -> PC_INC.
- LD_ADDR: mem_s=0 -> LD_WAIT.
- LD_WAIT: mem_s=0, mem_reg_en=1 -> LD_WB.
- LD_WB: wd_s=10, reg_wr=1 -> PC_INC.
- ST: mem_s=0, mem_we=1 for exactly one cycle -> PC_INC.
- BR_EX: alua_s=01, alub_s=01, se_sign=1, force_add=1, alu_out_en=1 -> BR_TAKE.
- BR_TAKE: pc_s=1, pc_en=1 -> FETCH.
- JMP: pc_s=0, pc_en=1 -> FETCH.
- PC_INC: alua_s=01, alub_s=10, force_add=1, alu_out_en=1 -> PC_WR.
- PC_WR: pc_s=1, pc_en=1 -> FETCH.
- Latency (FETCH to next FETCH):
  - R/I ALU 7; CMP 6; MOV 6; LOAD 8; STOR 6.
  - Branch taken 5, not taken 5; jump taken 4, not taken 5; illegal 5.
- Invariants: reg_wr and mem_we are never high together. pc_en is high for exactly one cycle per instruction.

Decomposition:
- Package cr16_ctrl_pkg holds:
  - state encodings (16 values);
  - op/ext constants;
  - condition-code constants;
  - PSR bit indices;
  - mux select constants (WD_IMM, WD_RSRC, WD_MEM, WD_ALU, ALUA_*, ALUB_*).
- One combinational sub-module, cr16_cond_eval (cond[3:0], psr[4:0] -> taken), shared with future branch-prediction work.

Test Plan:
- Reset held 3 cycles mid-LD_WAIT -> all outputs 0, state=FETCH on the first cycle after release; no reg_wr/mem_we.
- instr=0x0152 (ADD R1,R2) -> states FETCH,FLATCH,DECODE,EX_R,ALU_WB,PC_INC,PC_WR; psr_en only in EX_R; reg_wr with wd_s=11 only in ALU_WB; pc_en only in PC_WR.
- instr=0x4304 (LOAD R3,[R4]) -> mem_reg_en in LD_WAIT, reg_wr with wd_s=10 in LD_WB; 8 cycles total. instr=0x4344 (STOR) -> single mem_we pulse in ST with mem_s=0.
- instr=0xC0FE (BEQ -2): psr Z=1 -> BR_EX (se_sign=1, force_add=1) then BR_TAKE (pc_s=1); psr Z=0 -> DECODE goes straight to PC_INC.
- instr=0x4EC5 (JUC R5) -> JMP with pc_s=0, pc_en=1, then FETCH; 4 cycles. instr=0x4FC5 (cond 1111) -> PC_INC path.
- instr=0xE000 (undecoded op) -> illegal=1 for exactly one cycle in DECODE, no reg_wr/mem_we/psr_en; PC advances via PC_INC/PC_WR.
